// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle CPU controller: state encoding,
// instruction opcodes, instruction classes and the codes passed to the
// downstream ALU control decoder.
package multicycle_control_pkg;

  // Controller states; the encoding is visible on the 4-bit debug port.
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    R_EXEC   = 4'd7,
    R_WB     = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    I_EXEC   = 4'd11,
    I_WB     = 4'd12
  } state_t;

  // Instruction classes produced by the opcode classifier.
  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_LW      = 3'd1,
    CLS_SW      = 3'd2,
    CLS_RTYPE   = 3'd3,
    CLS_BEQ     = 3'd4,
    CLS_BNE     = 3'd5,
    CLS_JUMP    = 3'd6,
    CLS_IMM     = 3'd7
  } inst_class_t;

  // Opcodes (instruction bits [31:26]).
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALUop codes for the ALU control decoder.
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_IMM    = 2'b11;

  // funct_imm codes for immediate-form ALU operations.
  localparam logic [2:0] FI_ADD = 3'b000;
  localparam logic [2:0] FI_AND = 3'b001;
  localparam logic [2:0] FI_OR  = 3'b010;
  localparam logic [2:0] FI_XOR = 3'b011;
  localparam logic [2:0] FI_SLT = 3'b100;

  // PC source select.
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU B operand select.
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_SEXT  = 2'b10;
  localparam logic [1:0] SRCB_SHIFT = 2'b11;

endpackage

// File: rtl/mc_opdecode.sv
// Combinational opcode classifier for the multicycle controller.
// Ports:
//   opcode     in  6  instruction bits [31:26]
//   inst_class out 3  instruction class (CLS_ILLEGAL for undefined opcodes)
//   funct_imm  out 3  ALU function for immediate-form instructions, else 000
module mc_opdecode
  import multicycle_control_pkg::*;
(
  input  logic [5:0]  opcode,
  output inst_class_t inst_class,
  output logic [2:0]  funct_imm
);

  always_comb begin
    inst_class = CLS_ILLEGAL;
    funct_imm  = FI_ADD;
    case (opcode)
      OP_LW:    inst_class = CLS_LW;
      OP_SW:    inst_class = CLS_SW;
      OP_RTYPE: inst_class = CLS_RTYPE;
      OP_BEQ:   inst_class = CLS_BEQ;
      OP_BNE:   inst_class = CLS_BNE;
      OP_J:     inst_class = CLS_JUMP;
      OP_ADDI: begin
        inst_class = CLS_IMM;
        funct_imm  = FI_ADD;
      end
      OP_ANDI: begin
        inst_class = CLS_IMM;
        funct_imm  = FI_AND;
      end
      OP_ORI: begin
        inst_class = CLS_IMM;
        funct_imm  = FI_OR;
      end
      OP_XORI: begin
        inst_class = CLS_IMM;
        funct_imm  = FI_XOR;
      end
      OP_SLTI: begin
        inst_class = CLS_IMM;
        funct_imm  = FI_SLT;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU main controller.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   opcode              instruction bits [31:26] from the instruction register
//   mem_ready           memory access completes in the cycle it is 1
//   zero                ALU zero flag
//   PCWrite .. ALUSrcA  datapath strobes and selects
//   PCSource, ALUSrcB   datapath mux selects
//   ALUop, funct_imm    codes for the ALU control decoder
//   illegal_op          1-cycle pulse in DECODE on an undefined opcode
//   state               debug view of the current state
//   retired             count of completed instructions (wraps)
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  input  logic             zero,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             ALUSrcA,
  output logic             illegal_op,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUop,
  output logic [2:0]       funct_imm,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q;
  state_t           state_d;
  logic [5:0]       op_q;
  logic [5:0]       dec_op;
  inst_class_t      dec_cls;
  logic [2:0]       dec_fi;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  // One classifier serves every state: DECODE classifies the live opcode,
  // all later states classify the copy latched at the end of DECODE.
  assign dec_op = (state_q == DECODE) ? opcode : op_q;

  mc_opdecode u_opdecode (
    .opcode     (dec_op),
    .inst_class (dec_cls),
    .funct_imm  (dec_fi)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   state_d = FETCH;
      FETCH:  if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (dec_cls)
          CLS_LW, CLS_SW:   state_d = MEM_ADDR;
          CLS_RTYPE:        state_d = R_EXEC;
          CLS_BEQ, CLS_BNE: state_d = BRANCH;
          CLS_JUMP:         state_d = JUMP;
          CLS_IMM:          state_d = I_EXEC;
          default:          state_d = FETCH;
        endcase
      end
      MEM_ADDR: state_d = (dec_cls == CLS_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   if (mem_ready) state_d = MEM_WB;
      MEM_WB:   state_d = FETCH;
      MEM_WR:   if (mem_ready) state_d = FETCH;
      R_EXEC:   state_d = R_WB;
      R_WB:     state_d = FETCH;
      BRANCH:   state_d = FETCH;
      JUMP:     state_d = FETCH;
      I_EXEC:   state_d = I_WB;
      I_WB:     state_d = FETCH;
      default:  state_d = IDLE;
    endcase
  end

  // Only genuine instruction completions count: FETCH stalls, the first
  // fetch after IDLE and illegal-opcode returns from DECODE do not.
  assign retire = (state_d == FETCH) &&
                  (state_q != IDLE) && (state_q != FETCH) && (state_q != DECODE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) op_q <= opcode;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Output decode from the state register; reset forces IDLE, so every
  // strobe drops asynchronously with rst_n.
  always_comb begin
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    ALUSrcA    = 1'b0;
    illegal_op = 1'b0;
    PCSource   = PCSRC_ALU;
    ALUSrcB    = SRCB_REG;
    ALUop      = ALUOP_ADD;
    funct_imm  = FI_ADD;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      DECODE: begin
        ALUSrcB    = SRCB_SHIFT;
        illegal_op = (dec_cls == CLS_ILLEGAL);
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_SEXT;
      end
      MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUop   = ALUOP_RTYPE;
      end
      R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUop    = ALUOP_BRANCH;
        PCSource = PCSRC_ALUOUT;
        PCWrite  = ((dec_cls == CLS_BEQ) && zero) || ((dec_cls == CLS_BNE) && !zero);
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      I_EXEC: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_SEXT;
        ALUop     = ALUOP_IMM;
        funct_imm = dec_fi;
      end
      I_WB: begin
        RegWrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control. The DUT counter is
// narrowed to 4 bits so that wrap-around is reachable in a short run.
module tb_multicycle_control;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        zero;
  logic        PCWrite, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegWrite, RegDst, ALUSrcA, illegal_op;
  logic [1:0]  PCSource, ALUSrcB, ALUop;
  logic [2:0]  funct_imm;
  logic [3:0]  state;
  logic [3:0]  retired;
  logic [18:0] all_out;

  int unsigned vec;
  int unsigned err;
  logic [3:0]  exp_ret;

  multicycle_control #(.CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .zero       (zero),
    .PCWrite    (PCWrite),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .RegDst     (RegDst),
    .ALUSrcA    (ALUSrcA),
    .illegal_op (illegal_op),
    .PCSource   (PCSource),
    .ALUSrcB    (ALUSrcB),
    .ALUop      (ALUop),
    .funct_imm  (funct_imm),
    .state      (state),
    .retired    (retired)
  );

  assign all_out = {PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite,
                    RegDst, ALUSrcA, illegal_op, PCSource, ALUSrcB, ALUop, funct_imm};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; opcode = 6'b100011; mem_ready = 1'b1; zero = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    vec++; if (state !== 4'd0) begin err++; $display("FAIL reset_state: got %0d want 0", state); end
    vec++; if (retired !== 4'd0) begin err++; $display("FAIL reset_retired: got %0d want 0", retired); end
    vec++; if (all_out !== 19'd0) begin err++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    rst_n = 1'b1;
    #1;
    vec++; if (state !== 4'd0) begin err++; $display("FAIL release_idle: got %0d want 0", state); end
  endtask

  task automatic test_lw();
    logic [3:0] seq [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1};
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      if (i == 3) opcode = 6'b101011;  // sw on the bus after DECODE must not matter
      #1;
      vec++; if (state !== seq[i]) begin err++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, seq[i]); end
      vec++; if (RegWrite !== (seq[i] == 4'd5)) begin err++; $display("FAIL lw_regwrite[%0d]: got %b want %b", i, RegWrite, seq[i] == 4'd5); end
      if (i == 1) begin
        vec++; if ({MemRead, IorD, IRWrite, PCWrite, ALUSrcB} !== 6'b101101) begin err++; $display("FAIL lw_fetch_strobes: got %b want 101101", {MemRead, IorD, IRWrite, PCWrite, ALUSrcB}); end
      end
      if (i == 4) begin
        vec++; if ({MemRead, IorD} !== 2'b11) begin err++; $display("FAIL lw_memrd: got %b want 11", {MemRead, IorD}); end
      end
      if (i == 5) begin
        vec++; if ({RegWrite, MemtoReg, RegDst} !== 3'b110) begin err++; $display("FAIL lw_memwb: got %b want 110", {RegWrite, MemtoReg, RegDst}); end
      end
    end
    exp_ret = exp_ret + 4'd1;
    vec++; if (retired !== exp_ret) begin err++; $display("FAIL lw_retired: got %0d want %0d", retired, exp_ret); end
  endtask

  task automatic test_fetch_stall();
    mem_ready = 1'b0;
    opcode = 6'b000000;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick();
      if (c == 3) mem_ready = 1'b1;
      #1;
      vec++; if (state !== 4'd1) begin err++; $display("FAIL stall_state[%0d]: got %0d want 1", c, state); end
      vec++; if ({IRWrite, PCWrite} !== ((c == 3) ? 2'b11 : 2'b00)) begin err++; $display("FAIL stall_irpc[%0d]: got %b want %b", c, {IRWrite, PCWrite}, (c == 3) ? 2'b11 : 2'b00); end
    end
  endtask

  task automatic test_rtype();
    tick(); #1;
    vec++; if ({state, ALUSrcB, funct_imm} !== {4'd2, 2'b11, 3'b000}) begin err++; $display("FAIL r_decode: got %h want %h", {state, ALUSrcB, funct_imm}, {4'd2, 2'b11, 3'b000}); end
    tick(); #1;
    vec++; if ({state, ALUSrcA, ALUSrcB, ALUop} !== {4'd7, 1'b1, 2'b00, 2'b10}) begin err++; $display("FAIL r_exec: got %h want %h", {state, ALUSrcA, ALUSrcB, ALUop}, {4'd7, 1'b1, 2'b00, 2'b10}); end
    tick(); #1;
    vec++; if ({state, RegWrite, RegDst, MemtoReg} !== {4'd8, 3'b110}) begin err++; $display("FAIL r_wb: got %h want %h", {state, RegWrite, RegDst, MemtoReg}, {4'd8, 3'b110}); end
    tick(); #1;
    exp_ret = exp_ret + 4'd1;
    vec++; if ({state, retired} !== {4'd1, exp_ret}) begin err++; $display("FAIL r_done: got %h want %h", {state, retired}, {4'd1, exp_ret}); end
  endtask

  task automatic test_branch();
    logic [5:0] ops [3] = '{6'b000101, 6'b000101, 6'b000100};
    logic       zs  [3] = '{1'b0, 1'b1, 1'b1};
    logic       pcw [3] = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      opcode = ops[k];
      zero   = zs[k];
      tick();
      tick(); #1;
      vec++; if (state !== 4'd9) begin err++; $display("FAIL br_state[%0d]: got %0d want 9", k, state); end
      vec++; if (PCWrite !== pcw[k]) begin err++; $display("FAIL br_pcwrite[%0d]: got %b want %b", k, PCWrite, pcw[k]); end
      vec++; if ({PCSource, ALUop, ALUSrcA} !== 5'b01011) begin err++; $display("FAIL br_selects[%0d]: got %b want 01011", k, {PCSource, ALUop, ALUSrcA}); end
      tick(); #1;
      exp_ret = exp_ret + 4'd1;
      vec++; if ({state, retired} !== {4'd1, exp_ret}) begin err++; $display("FAIL br_done[%0d]: got %h want %h", k, {state, retired}, {4'd1, exp_ret}); end
    end
    zero = 1'b0;
  endtask

  task automatic test_imm();
    logic [5:0] ops [5] = '{6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010};
    logic [2:0] fis [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
    for (int k = 0; k < 5; k++) begin
      opcode = ops[k];
      tick(); #1;
      vec++; if ({state, funct_imm} !== {4'd2, 3'b000}) begin err++; $display("FAIL imm_decode[%0d]: got %h want %h", k, {state, funct_imm}, {4'd2, 3'b000}); end
      tick();
      opcode = 6'b111111;  // changing the bus after DECODE must not disturb funct_imm
      #1;
      vec++; if ({state, ALUop, funct_imm, ALUSrcB, ALUSrcA} !== {4'd11, 2'b11, fis[k], 2'b10, 1'b1}) begin err++; $display("FAIL imm_exec[%0d]: got %h want %h", k, {state, ALUop, funct_imm, ALUSrcB, ALUSrcA}, {4'd11, 2'b11, fis[k], 2'b10, 1'b1}); end
      tick(); #1;
      vec++; if ({state, RegWrite, RegDst, MemtoReg, funct_imm} !== {4'd12, 3'b100, 3'b000}) begin err++; $display("FAIL imm_wb[%0d]: got %h want %h", k, {state, RegWrite, RegDst, MemtoReg, funct_imm}, {4'd12, 3'b100, 3'b000}); end
      tick(); #1;
      exp_ret = exp_ret + 4'd1;
      vec++; if ({state, retired} !== {4'd1, exp_ret}) begin err++; $display("FAIL imm_done[%0d]: got %h want %h", k, {state, retired}, {4'd1, exp_ret}); end
    end
  endtask

  task automatic test_illegal();
    opcode = 6'b111111;
    tick(); #1;
    vec++; if ({state, illegal_op} !== {4'd2, 1'b1}) begin err++; $display("FAIL ill_pulse: got %h want %h", {state, illegal_op}, {4'd2, 1'b1}); end
    tick(); #1;
    vec++; if ({state, illegal_op} !== {4'd1, 1'b0}) begin err++; $display("FAIL ill_next: got %h want %h", {state, illegal_op}, {4'd1, 1'b0}); end
    vec++; if (retired !== exp_ret) begin err++; $display("FAIL ill_retired: got %0d want %0d", retired, exp_ret); end
  endtask

  task automatic test_jump_wrap();
    opcode = 6'b000010;
    for (int k = 0; k < 6; k++) begin
      tick();
      tick(); #1;
      vec++; if ({state, PCWrite, PCSource} !== {4'd10, 1'b1, 2'b10}) begin err++; $display("FAIL jump[%0d]: got %h want %h", k, {state, PCWrite, PCSource}, {4'd10, 1'b1, 2'b10}); end
      tick(); #1;
      exp_ret = exp_ret + 4'd1;
      vec++; if (retired !== exp_ret) begin err++; $display("FAIL jump_retired[%0d]: got %0d want %0d", k, retired, exp_ret); end
    end
  endtask

  task automatic test_reset_mid_write();
    opcode = 6'b101011;
    mem_ready = 1'b1;
    tick();
    tick(); #1;
    vec++; if (state !== 4'd3) begin err++; $display("FAIL sw_addr: got %0d want 3", state); end
    mem_ready = 1'b0;
    tick(); #1;
    vec++; if ({state, MemWrite, IorD} !== {4'd6, 2'b11}) begin err++; $display("FAIL sw_wr: got %h want %h", {state, MemWrite, IorD}, {4'd6, 2'b11}); end
    tick(); #1;
    vec++; if ({state, MemWrite} !== {4'd6, 1'b1}) begin err++; $display("FAIL sw_hold: got %h want %h", {state, MemWrite}, {4'd6, 1'b1}); end
    rst_n = 1'b0;
    #1;
    vec++; if ({state, MemWrite, retired} !== {4'd0, 1'b0, 4'd0}) begin err++; $display("FAIL async_reset: got %h want %h", {state, MemWrite, retired}, {4'd0, 1'b0, 4'd0}); end
    vec++; if (all_out !== 19'd0) begin err++; $display("FAIL async_outputs: got %h want 0", all_out); end
    #2 rst_n = 1'b1;
    mem_ready = 1'b1;
    tick(); #1;
    vec++; if ({state, retired} !== {4'd1, 4'd0}) begin err++; $display("FAIL post_reset: got %h want %h", {state, retired}, {4'd1, 4'd0}); end
  endtask

  initial begin
    vec = 0;
    err = 0;
    exp_ret = 4'd0;
    test_reset();
    test_lw();
    test_fetch_stall();
    test_rtype();
    test_branch();
    test_imm();
    test_illegal();
    test_jump_wrap();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 clk  in  1: single clock; all state changes on the rising edge.
REQ-003 rst_n  in  1: reset, asynchronous and active-low.
REQ-004 opcode  in  6: instruction bits [31:26], taken from the instruction register.
REQ-005 mem_ready  in  1: memory handshake; the access completes in the cycle it is 1.
REQ-006 zero  in  1: ALU zero flag.
REQ-007 Outputs, 1 bit each:
- PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA: standard multicycle datapath strobes and selects.
- illegal_op: 1-cycle pulse on an undefined opcode.
REQ-008 Multi-bit outputs:
- PCSource  out  2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- ALUSrcB  out  2: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted immediate.
REQ-009 ALUop  out  2 and funct_imm  out  3: drive the downstream ALU control decoder.
REQ-010 Status outputs:
- state  out  4: debug view of the current state.
- retired  out  CNT_W: count of completed instructions.

Function
REQ-011 States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, BRANCH, JUMP, I_EXEC, I_WB.
REQ-012 Outputs are decoded from the state register; a strobe not listed for a state is 0 in that state.
REQ-013 IDLE: all strobes are 0; the next state is always FETCH.
REQ-014 FETCH:
- Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00.
- IRWrite and PCWrite are 1 only when mem_ready=1.
- Holds in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
REQ-015 DECODE: drives ALUSrcA=0, ALUSrcB=11, ALUop=00. The next state depends on opcode:
- 100011 (lw) and 101011 (sw) -> MEM_ADDR.
- 000000 -> R_EXEC.
- 000100 (beq) and 000101 (bne) -> BRANCH.
- 000010 -> JUMP.
- 001000, 001100, 001101, 001110, 001010 -> I_EXEC.
- Any other opcode -> FETCH, with illegal_op=1 for that cycle.
REQ-016 MEM_ADDR: drives ALUSrcA=1, ALUSrcB=10, ALUop=00; goes to MEM_RD for lw, MEM_WR for sw.
REQ-017 MEM_RD: drives MemRead=1, IorD=1; holds until mem_ready=1, then goes to MEM_WB.
REQ-018 MEM_WB: drives RegWrite=1, MemtoReg=1, RegDst=0; goes to FETCH.
REQ-019 MEM_WR: drives MemWrite=1, IorD=1; holds until mem_ready=1, then goes to FETCH.
REQ-020 R_EXEC: drives ALUSrcA=1, ALUSrcB=00, ALUop=10; goes to R_WB.
REQ-021 R_WB: drives RegWrite=1, RegDst=1, MemtoReg=0; goes to FETCH.
REQ-022 BRANCH:
- Drives ALUSrcA=1, ALUSrcB=00, ALUop=01, PCSource=01.
- PCWrite=1 when (beq and zero=1) or (bne and zero=0).
- Goes to FETCH.
REQ-023 JUMP: drives PCWrite=1, PCSource=10; goes to FETCH.
REQ-024 I_EXEC:
- Drives ALUSrcA=1, ALUSrcB=10, ALUop=11.
- funct_imm by opcode: addi=000, andi=001, ori=010, xori=011, slti=100.
- Goes to I_WB.
REQ-025 I_WB: drives RegWrite=1, RegDst=0, MemtoReg=0; goes to FETCH.
REQ-026 The opcode is latched into an internal register on the DECODE cycle. Later states use the latched copy, so opcode changes after DECODE have no effect.
REQ-027 funct_imm is 000 in every state except I_EXEC.
REQ-028 retired increments by 1 on every transition into FETCH from a non-IDLE, non-DECODE state. Illegal opcodes are not counted.
REQ-029 retired wraps modulo 2^CNT_W.

Reset
REQ-030 rst_n=0 asynchronously forces the state to IDLE, clears retired and the latched opcode to 0, and forces all strobes, illegal_op, ALUop and funct_imm to 0.
REQ-031 Reset asserted during any state, including a held memory access, aborts the instruction. After rst_n rises, the first clock edge goes to FETCH.

Structure
REQ-032 The state encoding, opcode constants, ALUop codes and funct_imm codes belong in the shared CPU package.
REQ-033 One combinational sub-module, mc_opdecode, classifies the opcode into an instruction class and funct_imm.

Verification
REQ-034 Release reset with mem_ready=1 and opcode=100011 (lw) -> states IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, FETCH; RegWrite=1 only in MEM_WB; retired=1.
REQ-035 FETCH with mem_ready=0 for 3 cycles, then 1 -> state stays FETCH for 4 cycles; IRWrite and PCWrite are 1 only in the 4th cycle.
REQ-036 bne (000101) with zero=0 -> PCWrite=1 in BRANCH; bne with zero=1 -> PCWrite=0; both take 3 cycles.
REQ-037 opcode=001110 (xori) -> ALUop=11 and funct_imm=011 in I_EXEC; RegWrite=1 and RegDst=0 in I_WB.
REQ-038 opcode=111111 -> illegal_op pulses 1 in DECODE, the next state is FETCH, and retired is unchanged.
REQ-039 rst_n pulled low mid-MEM_WR -> MemWrite=0 immediately and state=IDLE without waiting for a clock; retired=0.
